// File: rtl/hs_bus_amba_axi_burst_addr_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hs_bus_amba_axi_burst_addr_gen_pkg
// Purpose  : Sequencer state encoding and WRAP length legality check.
// Revision : 1.0 - initial release
// ============================================================================
package hs_bus_amba_axi_burst_addr_gen_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } axbag_state_e;

    // WRAP bursts are restricted to 2, 4, 8 or 16 beats.
    function automatic logic is_legal_wrap_len(input logic [31:0] len);
        return (len == 32'd1) || (len == 32'd3) || (len == 32'd7) || (len == 32'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_bus_amba_axi_typedefs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hs_bus_amba_axi_typedefs_pkg
// Purpose  : Shared AMBA AXI encodings and bus-geometry helpers.
// Revision : 1.0 - initial release
// ============================================================================
package hs_bus_amba_axi_typedefs_pkg;

    typedef enum logic [1:0] {
        AxBURST_FIXED    = 2'b00,
        AxBURST_INCR     = 2'b01,
        AxBURST_WRAP     = 2'b10,
        AxBURST_RESERVED = 2'b11
    } axburst_e;

    // AxSIZE encoding of a full-width transfer on a bus of data_width bits.
    function automatic logic [2:0] get_axsize(input int data_width);
        logic [2:0] w_size;
        w_size = 3'd0;
        case (data_width)
            16:      w_size = 3'd1;
            32:      w_size = 3'd2;
            64:      w_size = 3'd3;
            128:     w_size = 3'd4;
            256:     w_size = 3'd5;
            512:     w_size = 3'd6;
            1024:    w_size = 3'd7;
            default: w_size = 3'd0;
        endcase
        return w_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_bus_amba_axi_next_addr.sv
`default_nettype none
// ============================================================================
// Module   : hs_bus_amba_axi_next_addr
// Purpose  : Combinational next-beat address and byte-lane range.
// Revision : 1.0 - initial release
// ============================================================================
module hs_bus_amba_axi_next_addr
    import hs_bus_amba_axi_typedefs_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int OFF_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] cur,
    input  logic [ADDR_WIDTH-1:0] aligned,
    input  logic [ADDR_WIDTH-1:0] lower,
    input  logic [ADDR_WIDTH-1:0] wsize,
    input  logic [2:0]            size,
    input  axburst_e              burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic [OFF_W-1:0]      next_lane_lo,
    output logic [OFF_W-1:0]      next_lane_hi
);

    localparam logic [ADDR_WIDTH-1:0] c_LANE_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);

    logic [ADDR_WIDTH-1:0] w_bytes;
    logic [ADDR_WIDTH-1:0] w_size_mask;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_wrap_end;
    logic [ADDR_WIDTH-1:0] w_offset;

    assign w_bytes     = ADDR_WIDTH'(1) << size;
    assign w_size_mask = w_bytes - ADDR_WIDTH'(1);
    // WRAP start addresses are size-aligned, so aligned + bytes covers both INCR and WRAP.
    assign w_step      = aligned + w_bytes;
    assign w_wrap_end  = lower + wsize;

    always_comb begin
        next_addr = cur;
        case (burst)
            AxBURST_INCR: next_addr = w_step;
            AxBURST_WRAP: next_addr = (w_step == w_wrap_end) ? lower : w_step;
            default:      next_addr = cur;
        endcase
    end

    assign w_offset     = next_addr & c_LANE_MASK;
    assign next_lane_lo = OFF_W'(w_offset);
    assign next_lane_hi = OFF_W'((w_offset & ~w_size_mask) + w_size_mask);

endmodule
`default_nettype wire

// File: rtl/hs_bus_amba_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : hs_bus_amba_axi_burst_addr_gen
// Purpose  : Expands one AXI AW/AR command into a registered per-beat stream.
// Revision : 1.0 - initial release
// ============================================================================
module hs_bus_amba_axi_burst_addr_gen
    import hs_bus_amba_axi_typedefs_pkg::*;
    import hs_bus_amba_axi_burst_addr_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8,
    localparam int c_OFF_W   = (get_axsize(DATA_WIDTH) == 3'd0) ? 1 : int'(get_axsize(DATA_WIDTH))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [2:0]            cmd_size,
    input  axburst_e              cmd_burst,
    output logic                  cmd_err,
    output logic                  beat_valid,
    input  logic                  beat_ready,
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [LEN_WIDTH-1:0]  beat_idx,
    output logic [c_OFF_W-1:0]    beat_lane_lo,
    output logic [c_OFF_W-1:0]    beat_lane_hi,
    output logic                  beat_last
);

    localparam logic [2:0]            c_MAX_SIZE  = get_axsize(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] c_LANE_MASK = ADDR_WIDTH'(DATA_WIDTH/8 - 1);

    axbag_state_e          r_state;
    axbag_state_e          w_state_nxt;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_lower;
    logic [ADDR_WIDTH-1:0] r_wsize;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [2:0]            r_size;
    axburst_e              r_burst;
    logic [c_OFF_W-1:0]    r_lane_lo;
    logic [c_OFF_W-1:0]    r_lane_hi;
    logic                  r_last;

    logic                  w_cmd_fire;
    logic                  w_beat_fire;
    logic                  w_cmd_illegal;
    logic [ADDR_WIDTH-1:0] w_cmd_mask;
    logic [ADDR_WIDTH-1:0] w_cmd_wsize;
    logic [ADDR_WIDTH-1:0] w_cmd_lower;
    logic [ADDR_WIDTH-1:0] w_cmd_offset;
    logic [c_OFF_W-1:0]    w_cmd_lane_lo;
    logic [c_OFF_W-1:0]    w_cmd_lane_hi;
    logic [ADDR_WIDTH-1:0] w_cur_aligned;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [c_OFF_W-1:0]    w_next_lane_lo;
    logic [c_OFF_W-1:0]    w_next_lane_hi;
    logic [LEN_WIDTH-1:0]  w_idx_nxt;

    assign cmd_ready   = (r_state == IDLE) && !rst;
    assign beat_valid  = (r_state == RUN);
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_beat_fire = beat_valid && beat_ready;

    // Command decode: masks, wrap window and legality.
    assign w_cmd_mask  = (ADDR_WIDTH'(1) << cmd_size) - ADDR_WIDTH'(1);
    assign w_cmd_wsize = (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << cmd_size;
    assign w_cmd_lower = cmd_addr & ~(w_cmd_wsize - ADDR_WIDTH'(1));

    assign w_cmd_illegal = (cmd_size > c_MAX_SIZE)
                        || (cmd_burst == AxBURST_RESERVED)
                        || ((cmd_burst == AxBURST_WRAP)
                            && (!is_legal_wrap_len(32'(cmd_len))
                                || ((cmd_addr & w_cmd_mask) != '0)));

    assign w_cmd_offset  = cmd_addr & c_LANE_MASK;
    assign w_cmd_lane_lo = c_OFF_W'(w_cmd_offset);
    assign w_cmd_lane_hi = c_OFF_W'((w_cmd_offset & ~w_cmd_mask) + w_cmd_mask);

    assign w_cur_aligned = r_addr & ~((ADDR_WIDTH'(1) << r_size) - ADDR_WIDTH'(1));
    assign w_idx_nxt     = r_idx + LEN_WIDTH'(1);

    hs_bus_amba_axi_next_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .OFF_W      (c_OFF_W)
    ) u_next_addr (
        .cur          (r_addr),
        .aligned      (w_cur_aligned),
        .lower        (r_lower),
        .wsize        (r_wsize),
        .size         (r_size),
        .burst        (r_burst),
        .next_addr    (w_next_addr),
        .next_lane_lo (w_next_lane_lo),
        .next_lane_hi (w_next_lane_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_cmd_fire && !w_cmd_illegal) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_beat_fire && r_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_lower   <= '0;
            r_wsize   <= '0;
            r_idx     <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= AxBURST_FIXED;
            r_lane_lo <= '0;
            r_lane_hi <= '0;
            r_last    <= 1'b0;
        end else begin
            r_err <= w_cmd_fire && w_cmd_illegal;
            if (w_cmd_fire && !w_cmd_illegal) begin
                r_addr    <= cmd_addr;
                r_lower   <= w_cmd_lower;
                r_wsize   <= w_cmd_wsize;
                r_idx     <= '0;
                r_len     <= cmd_len;
                r_size    <= cmd_size;
                r_burst   <= cmd_burst;
                r_lane_lo <= w_cmd_lane_lo;
                r_lane_hi <= w_cmd_lane_hi;
                r_last    <= (cmd_len == '0);
            end else if (w_beat_fire && !r_last) begin
                r_addr    <= w_next_addr;
                r_idx     <= w_idx_nxt;
                r_lane_lo <= w_next_lane_lo;
                r_lane_hi <= w_next_lane_hi;
                r_last    <= (w_idx_nxt == r_len);
            end
        end
    end

    assign cmd_err      = r_err;
    assign beat_addr    = r_addr;
    assign beat_idx     = r_idx;
    assign beat_lane_lo = r_lane_lo;
    assign beat_lane_hi = r_lane_hi;
    assign beat_last    = r_last;

endmodule
`default_nettype wire

// File: tb/tb_hs_bus_amba_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_bus_amba_axi_burst_addr_gen
// Purpose  : Directed self-checking bench for the AXI burst address sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_bus_amba_axi_burst_addr_gen;
    import hs_bus_amba_axi_typedefs_pkg::*;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int LEN_WIDTH  = 8;

    logic                  clk;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [2:0]            cmd_size;
    axburst_e              cmd_burst;
    logic                  cmd_err;
    logic                  beat_valid;
    logic                  beat_ready;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [2:0]            beat_lane_lo;
    logic [2:0]            beat_lane_hi;
    logic                  beat_last;

    int checks = 0;
    int errors = 0;

    hs_bus_amba_axi_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_size     (cmd_size),
        .cmd_burst    (cmd_burst),
        .cmd_err      (cmd_err),
        .beat_valid   (beat_valid),
        .beat_ready   (beat_ready),
        .beat_addr    (beat_addr),
        .beat_idx     (beat_idx),
        .beat_lane_lo (beat_lane_lo),
        .beat_lane_hi (beat_lane_hi),
        .beat_last    (beat_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] addr, input int idx,
                               input int lo, input int hi, input logic last);
        check({tag, " valid"}, 64'(beat_valid), 64'd1);
        check({tag, " addr"},  64'(beat_addr),  64'(addr));
        check({tag, " idx"},   64'(beat_idx),   64'(idx));
        check({tag, " lo"},    64'(beat_lane_lo), 64'(lo));
        check({tag, " hi"},    64'(beat_lane_hi), 64'(hi));
        check({tag, " last"},  64'(beat_last),  64'(last));
    endtask

    task automatic send_cmd(input string tag, input logic [31:0] addr, input int len,
                            input int size, input axburst_e burst);
        check({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
        cmd_addr  = addr;
        cmd_len   = LEN_WIDTH'(len);
        cmd_size  = 3'(size);
        cmd_burst = burst;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " idle valid"}, 64'(beat_valid), 64'd0);
        check({tag, " idle ready"}, 64'(cmd_ready),  64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_len    = '0;
        cmd_size   = '0;
        cmd_burst  = AxBURST_INCR;
        beat_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst cmd_err",   64'(cmd_err),   64'd0);
        check("rst valid",     64'(beat_valid), 64'd0);
        check("rst addr",      64'(beat_addr), 64'd0);
        check("rst idx",       64'(beat_idx),  64'd0);
        check("rst lo",        64'(beat_lane_lo), 64'd0);
        check("rst hi",        64'(beat_lane_hi), 64'd0);
        check("rst last",      64'(beat_last), 64'd0);
        rst = 1'b0;
        step();
        check("post-rst cmd_ready", 64'(cmd_ready), 64'd1);

        // INCR aligned-to-size, four 4-byte beats
        send_cmd("incr", 32'h1004, 3, 2, AxBURST_INCR);
        check("incr busy ready", 64'(cmd_ready), 64'd0);
        beat_ready = 1'b1;
        expect_beat("incr b0", 32'h1004, 0, 4, 7, 1'b0); step();
        expect_beat("incr b1", 32'h1008, 1, 0, 3, 1'b0); step();
        expect_beat("incr b2", 32'h100C, 2, 4, 7, 1'b0); step();
        expect_beat("incr b3", 32'h1010, 3, 0, 3, 1'b1); step();
        expect_idle("incr");
        beat_ready = 1'b0;

        // INCR unaligned start
        send_cmd("unal", 32'h1003, 1, 3, AxBURST_INCR);
        beat_ready = 1'b1;
        expect_beat("unal b0", 32'h1003, 0, 3, 7, 1'b0); step();
        expect_beat("unal b1", 32'h1008, 1, 0, 7, 1'b1); step();
        expect_idle("unal");
        beat_ready = 1'b0;

        // WRAP: 32-byte window at 0x20
        send_cmd("wrap", 32'h38, 3, 3, AxBURST_WRAP);
        beat_ready = 1'b1;
        expect_beat("wrap b0", 32'h38, 0, 0, 7, 1'b0); step();
        expect_beat("wrap b1", 32'h20, 1, 0, 7, 1'b0); step();
        expect_beat("wrap b2", 32'h28, 2, 0, 7, 1'b0); step();
        expect_beat("wrap b3", 32'h30, 3, 0, 7, 1'b1); step();
        expect_idle("wrap");
        beat_ready = 1'b0;

        // FIXED with back-pressure; a command offered mid-burst is ignored
        send_cmd("fixed", 32'h100, 2, 3, AxBURST_FIXED);
        beat_ready = 1'b1;
        expect_beat("fixed b0", 32'h100, 0, 0, 7, 1'b0); step();
        beat_ready = 1'b0;
        cmd_valid  = 1'b1;
        cmd_addr   = 32'h5000;
        cmd_len    = 8'd0;
        cmd_size   = 3'd3;
        cmd_burst  = AxBURST_INCR;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_beat("fixed hold", 32'h100, 1, 0, 7, 1'b0);
            check("fixed hold ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid  = 1'b0;
        beat_ready = 1'b1;
        step();
        expect_beat("fixed b2", 32'h100, 2, 0, 7, 1'b1); step();
        expect_idle("fixed");
        beat_ready = 1'b0;

        // Single-beat burst
        send_cmd("len0", 32'h200, 0, 3, AxBURST_INCR);
        beat_ready = 1'b1;
        expect_beat("len0 b0", 32'h200, 0, 0, 7, 1'b1); step();
        expect_idle("len0");
        beat_ready = 1'b0;

        // Illegal: WRAP with len 2
        send_cmd("ill wrap", 32'h40, 2, 3, AxBURST_WRAP);
        check("ill wrap err",   64'(cmd_err),    64'd1);
        check("ill wrap valid", 64'(beat_valid), 64'd0);
        check("ill wrap ready", 64'(cmd_ready),  64'd1);
        step();
        check("ill wrap err drop", 64'(cmd_err), 64'd0);
        check("ill wrap no beat",  64'(beat_valid), 64'd0);

        // Illegal: size wider than the bus
        send_cmd("ill size", 32'h80, 0, 4, AxBURST_INCR);
        check("ill size err",   64'(cmd_err),    64'd1);
        check("ill size valid", 64'(beat_valid), 64'd0);
        check("ill size ready", 64'(cmd_ready),  64'd1);
        step();
        check("ill size err drop", 64'(cmd_err), 64'd0);
        check("ill size no beat",  64'(beat_valid), 64'd0);

        // Reset in the middle of an eight-beat burst
        send_cmd("mid", 32'h2000, 7, 3, AxBURST_INCR);
        beat_ready = 1'b1;
        expect_beat("mid b0", 32'h2000, 0, 0, 7, 1'b0); step();
        expect_beat("mid b1", 32'h2008, 1, 0, 7, 1'b0); step();
        expect_beat("mid b2", 32'h2010, 2, 0, 7, 1'b0);
        rst = 1'b1;
        step();
        check("mid rst valid", 64'(beat_valid), 64'd0);
        check("mid rst err",   64'(cmd_err),    64'd0);
        check("mid rst addr",  64'(beat_addr),  64'd0);
        check("mid rst idx",   64'(beat_idx),   64'd0);
        check("mid rst ready", 64'(cmd_ready),  64'd0);
        rst = 1'b0;
        beat_ready = 1'b0;
        step();
        check("mid rst err after", 64'(cmd_err), 64'd0);
        send_cmd("after", 32'h3000, 1, 2, AxBURST_INCR);
        beat_ready = 1'b1;
        expect_beat("after b0", 32'h3000, 0, 0, 3, 1'b0); step();
        expect_beat("after b1", 32'h3004, 1, 4, 7, 1'b1); step();
        expect_idle("after");
        beat_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
